// File: rtl/div_sequencer.sv
// Restoring-division sequencer for RV32M DIV/DIVU/REM/REMU built around one shared add/sub.
// Define DIV_SIGNED_EN for signed DIV/REM; without it every op is handled as unsigned.

module adder_n_subtractor #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    output logic [N-1:0] s
);
    // c=1 yields b - a in two's complement, c=0 yields b + a
    assign s = b + (a ^ {N{c}}) + {{(N-1){1'b0}}, c};
endmodule

module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            rem_sel_q;

    logic            accept;
    logic            sub_en;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_val;
    logic [XLEN:0]   r_shift;
    logic [XLEN:0]   sum;

`ifdef DIV_SIGNED_EN
    logic            sgn_q;
    logic            qneg_q;
    logic            rneg_q;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic en);
        return (en && x[XLEN-1]) ? negate(x) : x;
    endfunction

    assign dvd_mag  = magnitude(dvd_q, sgn_q);
    assign dvs_mag  = magnitude(dvs_q, sgn_q);
    assign overflow = sgn_q && (dvd_q == {1'b1, {(XLEN-1){1'b0}}}) && (dvs_q == '1);
    assign quo_fix  = qneg_q ? negate(quo_q) : quo_q;
    assign rem_fix  = rneg_q ? negate(rem_q) : rem_q;
`else
    logic            unused_op0;

    assign unused_op0 = op[0];
    assign dvd_mag    = dvd_q;
    assign dvs_mag    = dvs_q;
    assign overflow   = 1'b0;
    assign quo_fix    = quo_q;
    assign rem_fix    = rem_q;
`endif

    assign div_zero = (dvs_q == '0);
    assign special  = div_zero || overflow;
    assign fix_val  = rem_sel_q ? rem_fix : quo_fix;
    assign r_shift  = {rem_q, quo_q[XLEN-1]};

    adder_n_subtractor #(.N(XLEN + 1)) u_addsub (
        .a ({1'b0, dvs_q}),
        .b (r_shift),
        .c (sub_en),
        .s (sum)
    );

    // FIX doubles as the completion cycle: busy is low and a new start is taken
    assign result = (state == FIX) ? fix_val : result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == FIX) begin
                result_q <= fix_val;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        sub_en    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_nxt = PREP;
                end
            end
            PREP: begin
                busy      = 1'b1;
                state_nxt = special ? FIX : ITER;
            end
            ITER: begin
                busy   = 1'b1;
                sub_en = 1'b1;
                if (cnt_q == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? PREP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q     <= dividend;
            dvs_q     <= divisor;
            rem_sel_q <= op[1];
`ifdef DIV_SIGNED_EN
            sgn_q     <= ~op[0];
`endif
        end
        case (state)
            PREP: begin
                // special results bypass iteration and travel through FIX with no sign fix-up
                if (div_zero) begin
                    quo_q <= '1;
                    rem_q <= dvd_q;
                end else if (overflow) begin
                    quo_q <= dvd_q;
                    rem_q <= '0;
                end else begin
                    quo_q <= dvd_mag;
                    rem_q <= '0;
                    dvs_q <= dvs_mag;
                    cnt_q <= CW'(XLEN - 1);
                end
`ifdef DIV_SIGNED_EN
                qneg_q <= ~special & sgn_q & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                rneg_q <= ~special & sgn_q & dvd_q[XLEN-1];
`endif
            end
            ITER: begin
                quo_q <= {quo_q[XLEN-2:0], ~sum[XLEN]};
                rem_q <= sum[XLEN] ? r_shift[XLEN-1:0] : sum[XLEN-1:0];
                cnt_q <= cnt_q - 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes expected results, a monitor pops on done.
module tb_div_sequencer;
    localparam int XLEN   = 32;
    localparam int LAT    = XLEN + 2;
    localparam int LAT_SP = 2;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [XLEN-1:0] res;
        int              due;
        string           tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, req);
        end
    endtask

    function automatic bit is_signed(input logic [1:0] o);
        return SIGNED_EN && !o[0];
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return (b == 0) || (is_signed(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RV32M results straight from arithmetic, with the two special cases listed explicitly
    function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : '1;
        if (is_signed(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? '0 : a;
        if (is_signed(o)) return o[1] ? sa % sb : sa / sb;
        return o[1] ? a % b : a / b;
    endfunction

    task automatic issue(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input int lat);
        exp_t x;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        x.res    = e;
        x.due    = cyc + lat;
        x.tag    = tag;
        exp_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result 0x%h at cycle %0d, required no done", result, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_result"}, result, mon_e.res);
                check({mon_e.tag, "_cycle"}, cyc, mon_e.due);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        logic [1:0]      ro;
        logic [XLEN-1:0] ra, rb;
        int              sel;

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        rst = 1'b0;
        @(negedge clk);

        k = cyc;
        issue("divu_100_7", 2'b01, 100, 7, 14, LAT);
        check("busy_first", busy, 1'b1);
        repeat (32) @(negedge clk);
        check("busy_last", busy, 1'b1);
        check("done_early", done, 1'b0);
        @(negedge clk);
        check("done_cycle_busy", busy, 1'b0);
        check("done_cycle_done", done, 1'b1);
        check("done_cycle_index", cyc, k + 34);
        drain();

        issue("remu_100_7", 2'b11, 100, 7, 2, LAT);
        drain();
        repeat (3) @(negedge clk);
        check("result_held", result, 2);

        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 2, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, LAT);
        drain();
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 2, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001, LAT);
        drain();

        issue("divu_5_0", 2'b01, 5, 0, 32'hFFFF_FFFF, LAT_SP);
        drain();
        issue("remu_5_0", 2'b11, 5, 0, 5, LAT_SP);
        drain();
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
              SIGNED_EN ? 32'h8000_0000 : 32'h0, SIGNED_EN ? LAT_SP : LAT);
        drain();
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              SIGNED_EN ? 32'h0 : 32'h8000_0000, SIGNED_EN ? LAT_SP : LAT);
        drain();

        // a start in the middle of an operation must be ignored
        issue("divu_ignore", 2'b01, 1000, 10, 100, LAT);
        repeat (9) @(negedge clk);
        start    = 1'b1;
        op       = 2'b11;
        dividend = 77;
        divisor  = 5;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-flight drops the operation without a done
        issue("divu_rst", 2'b01, 50, 5, 10, LAT);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue("divu_9_3", 2'b01, 9, 3, 3, LAT);
        drain();

        // back-to-back: next start presented in the done cycle
        issue("b2b_first", 2'b01, 100, 7, 14, LAT);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL b2b_wait: done=%b after %0d cycles, required 1", done, n);
        end
        issue("b2b_second", 2'b11, 17, 5, 2, LAT);
        drain();

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 0;
            else if (sel == 1) rb = $urandom_range(1, 15);
            else if (sel == 2) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 3) ra = $urandom_range(0, 100);
            issue($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb),
                  is_special(ro, ra, rb) ? LAT_SP : LAT);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
